// File: rtl/rf_writeback_arbiter_if.sv
// rf_writeback_arbiter_if: writeback request channels, register-file write port and hazard status.
interface rf_writeback_arbiter_if #(parameter int XLEN = 32);
  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lsu_valid;
  logic            lsu_ready;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            rf_hold;
  logic            rf_we;
  logic [4:0]      rf_wa;
  logic [XLEN-1:0] rf_wdata;
  logic [31:0]     pending;
  logic [31:0]     wb_count;
  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, rf_hold,
    output alu_ready, lsu_ready, rf_we, rf_wa, rf_wdata, pending, wb_count
  );
  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, rf_hold,
    input  alu_ready, lsu_ready, rf_we, rf_wa, rf_wdata, pending, wb_count
  );
endinterface

// File: rtl/rf_writeback_arbiter.sv
// rf_writeback_arbiter: arbitrates ALU/LSU writebacks into an in-order FIFO feeding the register-file write port.
module rf_writeback_arbiter #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input logic clk,
  input logic reset,
  rf_writeback_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d, alu_wa;
  logic [CW-1:0]   count_q, count_d, free;
  logic [1:0]      starve_q, starve_d;
  logic [31:0]     wb_q, wb_d, pend;
  logic [4:0]      rd_mem_q [DEPTH];
  logic [XLEN-1:0] data_mem_q [DEPTH];
  logic            both, lsu_rdy, alu_rdy, push_l, push_a, pop;
  always_comb begin
    free     = CW'(DEPTH) - count_q;
    both     = bus.alu_valid && bus.lsu_valid;
    // With a single free slot and both sources asking, LSU wins unless the ALU has been starved twice.
    lsu_rdy  = !reset && |free && (!both || free >= CW'(2) || starve_q != 2'd2);
    alu_rdy  = !reset && |free && (!both || free >= CW'(2) || starve_q == 2'd2);
    push_l   = bus.lsu_valid && lsu_rdy && |bus.lsu_rd;
    push_a   = bus.alu_valid && alu_rdy && |bus.alu_rd;
    pop      = !reset && |count_q && !bus.rf_hold;
    alu_wa   = wr_q + PW'(push_l);
    wr_d     = alu_wa + PW'(push_a);
    rd_d     = rd_q + PW'(pop);
    count_d  = count_q + CW'(push_l) + CW'(push_a) - CW'(pop);
    starve_d = (bus.alu_valid && alu_rdy) ? 2'd0 :
               (both && lsu_rdy && starve_q != 2'd2) ? starve_q + 2'd1 : starve_q;
    wb_d     = wb_q + 32'(pop);
    pend     = '0;
    for (int i = 0; i < DEPTH; i++)
      if (CW'(i) < count_q) pend[rd_mem_q[rd_q + PW'(i)]] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q     <= '0;
      rd_q     <= '0;
      count_q  <= '0;
      starve_q <= '0;
      wb_q     <= '0;
    end else begin
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      wb_q     <= wb_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push_l) begin
      rd_mem_q[wr_q]   <= bus.lsu_rd;
      data_mem_q[wr_q] <= bus.lsu_data;
    end
    if (push_a) begin
      rd_mem_q[alu_wa]   <= bus.alu_rd;
      data_mem_q[alu_wa] <= bus.alu_data;
    end
  end
  assign bus.lsu_ready = lsu_rdy;
  assign bus.alu_ready = alu_rdy;
  assign bus.rf_we     = pop;
  assign bus.rf_wa     = rd_mem_q[rd_q];
  assign bus.rf_wdata  = data_mem_q[rd_q];
  assign bus.pending   = reset ? '0 : pend;
  assign bus.wb_count  = wb_q;
endmodule
